// File: rtl/hyper_eot_evt_router.sv
// Per-channel router of HyperBus EOT pulses onto read-EOT / write-EOT events, using a direction FIFO (MODE=1) or a sticky last-direction register (MODE=0).
// Latency: every evt_o bit follows its cause by exactly one cycle; level_o and the error flags update on the same edge.
// Backpressure: none; a launch into a full queue is dropped and flagged, and an EOT with nothing to route is flagged.
module hyper_eot_evt_router #(
    parameter  int NB_CH = 2,
    parameter  int DEPTH = 4,
    parameter  int MODE  = 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   sys_clk_i,
    input  logic                   rstn_i,
    input  logic                   clr_i,
    input  logic [NB_CH-1:0]       rx_evt_i,
    input  logic [NB_CH-1:0]       tx_evt_i,
    input  logic [NB_CH-1:0]       eot_i,
    output logic [4*NB_CH-1:0]     evt_o,
    output logic [NB_CH*CNT_W-1:0] level_o,
    output logic [NB_CH-1:0]       err_ovf_o,
    output logic [NB_CH-1:0]       err_udf_o,
    output logic [NB_CH-1:0]       err_conf_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    for (genvar c = 0; c < NB_CH; c++) begin : g_ch
        logic rx;
        logic tx;
        logic eot;
        logic push;
        logic conf;

        assign rx   = rx_evt_i[c];
        assign tx   = tx_evt_i[c];
        assign eot  = eot_i[c];
        assign push = rx ^ tx;
        assign conf = rx & tx;

        // Filled in by the mode-specific block: which way this cycle's EOT goes, if at all.
        logic             route_vld;
        logic             route_dir;
        logic             ovf_set;
        logic             udf_set;
        logic [CNT_W-1:0] level;

        if (MODE == 0) begin : g_sticky
            logic dir_d;
            logic dir_q;

            always_comb begin
                dir_d = dir_q;
                if (clr_i) begin
                    dir_d = 1'b0;
                end else if (push) begin
                    dir_d = rx;
                end
            end

            // A launch in the EOT cycle decides that EOT.
            assign route_vld = eot;
            assign route_dir = push ? rx : dir_q;
            assign ovf_set   = 1'b0;
            assign udf_set   = 1'b0;
            assign level     = '0;

            always_ff @(posedge sys_clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    dir_q <= 1'b0;
                end else begin
                    dir_q <= dir_d;
                end
            end
        end else begin : g_fifo
            logic [DEPTH-1:0] mem_d;
            logic [DEPTH-1:0] mem_q;
            logic [PTR_W-1:0] rd_ptr_d;
            logic [PTR_W-1:0] rd_ptr_q;
            logic [PTR_W-1:0] wr_ptr_d;
            logic [PTR_W-1:0] wr_ptr_q;
            logic [CNT_W-1:0] cnt_d;
            logic [CNT_W-1:0] cnt_q;
            logic             empty;
            logic             full;
            logic             pop;
            logic             store;

            assign empty = (cnt_q == '0);
            assign full  = (cnt_q == CNT_FULL);

            always_comb begin
                mem_d     = mem_q;
                rd_ptr_d  = rd_ptr_q;
                wr_ptr_d  = wr_ptr_q;
                cnt_d     = cnt_q;
                pop       = 1'b0;
                store     = 1'b0;
                route_vld = 1'b0;
                route_dir = 1'b0;
                ovf_set   = 1'b0;
                udf_set   = 1'b0;

                if (clr_i) begin
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                end else begin
                    if (eot) begin
                        if (!empty) begin
                            pop       = 1'b1;
                            route_vld = 1'b1;
                            route_dir = mem_q[rd_ptr_q];
                        end else if (push) begin
                            // Empty queue: the launch is consumed directly by this EOT.
                            route_vld = 1'b1;
                            route_dir = rx;
                        end else begin
                            udf_set = 1'b1;
                        end
                    end

                    if (push && !(eot && empty)) begin
                        if (!full || pop) begin
                            store = 1'b1;
                        end else begin
                            ovf_set = 1'b1;
                        end
                    end

                    if (pop) begin
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                    end
                    if (store) begin
                        mem_d[wr_ptr_q] = rx;
                        wr_ptr_d        = ptr_inc(wr_ptr_q);
                    end
                    if (store && !pop) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (pop && !store) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            assign level = cnt_q;

            always_ff @(posedge sys_clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    mem_q    <= '0;
                    rd_ptr_q <= '0;
                    wr_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    mem_q    <= mem_d;
                    rd_ptr_q <= rd_ptr_d;
                    wr_ptr_q <= wr_ptr_d;
                    cnt_q    <= cnt_d;
                end
            end
        end

        logic [3:0] evt_d;
        logic [3:0] evt_q;
        logic       ovf_d;
        logic       ovf_q;
        logic       udf_d;
        logic       udf_q;
        logic       conf_d;
        logic       conf_q;

        always_comb begin
            evt_d  = {2'b00, tx, rx};
            ovf_d  = ovf_q | ovf_set;
            udf_d  = udf_q | udf_set;
            conf_d = conf_q | conf;
            if (clr_i) begin
                ovf_d  = 1'b0;
                udf_d  = 1'b0;
                conf_d = 1'b0;
            end else if (route_vld) begin
                evt_d[3] = ~route_dir;
                evt_d[2] = route_dir;
            end
        end

        always_ff @(posedge sys_clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                evt_q  <= '0;
                ovf_q  <= 1'b0;
                udf_q  <= 1'b0;
                conf_q <= 1'b0;
            end else begin
                evt_q  <= evt_d;
                ovf_q  <= ovf_d;
                udf_q  <= udf_d;
                conf_q <= conf_d;
            end
        end

        assign evt_o[4*c +: 4]          = evt_q;
        assign level_o[c*CNT_W +: CNT_W] = level;
        assign err_ovf_o[c]             = ovf_q;
        assign err_udf_o[c]             = udf_q;
        assign err_conf_o[c]            = conf_q;
    end

endmodule
